// File: rtl/mux64_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux64_rr_arbiter
//
// Round-robin arbiter and sequencer for a shared 2:1 select datapath.
// Each cycle it picks which requester's word passes the mux. It captures
// that word into a one-entry output register and presents the register
// downstream with a VALID/READY handshake.
//
// Parameters
//   DATA_W      width of each data word and of the output register
//   FIRST_PRIO  requester that wins the first contested arbitration
//
// Ports
//   CLK         rising-edge clock
//   RST         synchronous active-low reset
//   REQ0/DATA0  requester 0 request and word; GNT0 = DATA0 captured this edge
//   REQ1/DATA1  requester 1 request and word; GNT1 = DATA1 captured this edge
//   OUT_VALID   output register holds a word
//   OUT_READY   consumer accepts the held word this cycle
//   OUT_DATA    held word
//   OUT_SRC     index of the requester that supplied OUT_DATA
//   SEL         mux select: the granted index during a grant, else last value
//
// Optional feature (macro ARB_LOCK_EN)
//   Adds LOCK0/LOCK1. A grant taken with LOCKk=1 locks the arbiter to
//   requester k until k is granted with LOCKk=0 or k drops its REQ.
// ---------------------------------------------------------------------------
module mux64_rr_arbiter #(
  parameter int   DATA_W     = 64,
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic [DATA_W-1:0] DATA0,
  output logic              GNT0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              GNT1,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
`ifdef ARB_LOCK_EN
  input  logic              LOCK0,
  input  logic              LOCK1,
`endif
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_SRC,
  output logic              SEL
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q, src_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;

  logic              accept;
  logic              elig0, elig1;
  logic              gnt0, gnt1, gnt_any;
  logic              sel_now;
  logic [DATA_W-1:0] mux_word;

`ifdef ARB_LOCK_EN
  logic              locked_q, locked_d;
  logic              owner_q, owner_d;
  logic              owner_req;
  logic              lock_req;
`endif

  // Requests that may compete this cycle. While locked, only the owner's
  // request is visible; the other requester is held off.
  always_comb begin
    elig0 = REQ0;
    elig1 = REQ1;
`ifdef ARB_LOCK_EN
    if (locked_q) begin
      elig0 = REQ0 & ~owner_q;
      elig1 = REQ1 &  owner_q;
    end
`endif
  end

  // Mealy grant. The register can take a word when empty or when the held
  // word leaves this same cycle, so drain and refill overlap.
  always_comb begin
    accept = (state_q == S_EMPTY) | (OUT_READY & (state_q == S_FULL));
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if (RST && accept) begin
      if (elig0 && elig1) begin
        // Contested: the requester not served last wins.
        gnt0 =  last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
    gnt_any = gnt0 | gnt1;
  end

  // The select follows the live grant so the mux already points at the
  // winning word in the grant cycle; otherwise it parks on its last value.
  always_comb begin
    sel_now  = gnt_any ? gnt1 : sel_q;
    mux_word = sel_now ? DATA1 : DATA0;
  end

`ifdef ARB_LOCK_EN
  always_comb begin
    lock_req  = gnt1 ? LOCK1 : LOCK0;
    owner_req = owner_q ? REQ1 : REQ0;
  end
`endif

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    sel_d   = sel_q;
`ifdef ARB_LOCK_EN
    locked_d = locked_q;
    owner_d  = owner_q;
`endif
    if (gnt_any) begin
      state_d = S_FULL;
      data_d  = mux_word;
      src_d   = gnt1;
      last_d  = gnt1;
      sel_d   = gnt1;
    end else if ((state_q == S_FULL) && OUT_READY) begin
      // Drain without refill: the stale word stays visible but not valid.
      state_d = S_EMPTY;
    end
`ifdef ARB_LOCK_EN
    if (gnt_any) begin
      if (lock_req) begin
        locked_d = 1'b1;
        owner_d  = gnt1;
      end else if (locked_q) begin
        // Only the owner can be granted while locked, so this is the
        // owner releasing the lock.
        locked_d = 1'b0;
      end
    end else if (locked_q && !owner_req) begin
      locked_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      src_q   <= 1'b0;
      last_q  <= ~FIRST_PRIO;
      sel_q   <= 1'b0;
`ifdef ARB_LOCK_EN
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
`ifdef ARB_LOCK_EN
      locked_q <= locked_d;
      owner_q  <= owner_d;
`endif
    end
  end

  assign GNT0      = gnt0;
  assign GNT1      = gnt1;
  assign SEL       = sel_now;
  assign OUT_VALID = (state_q == S_FULL);
  assign OUT_DATA  = data_q;
  assign OUT_SRC   = src_q;

endmodule

// File: tb/tb_mux64_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux64_rr_arbiter
//
// Bench for mux64_rr_arbiter: a table of single-cycle vectors walking the
// directed scenarios, then randomized traffic checked against a queue-based
// reference model, plus a lock sequence when ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_mux64_rr_arbiter;
  localparam int          DATA_W     = 64;
  localparam logic        FIRST_PRIO = 1'b0;
  localparam logic [63:0] WA = 64'd4294967294;
  localparam logic [63:0] WB = 64'd4294967295;
  localparam logic [63:0] WC = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] WD = 64'h8000_0000_0000_0001;

  logic              CLK = 1'b0;
  logic              RST;
  logic              REQ0, REQ1, OUT_READY;
  logic [DATA_W-1:0] DATA0, DATA1, OUT_DATA;
  logic              GNT0, GNT1, OUT_VALID, OUT_SRC, SEL;
`ifdef ARB_LOCK_EN
  logic              LOCK0, LOCK1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mux64_rr_arbiter #(.DATA_W(DATA_W), .FIRST_PRIO(FIRST_PRIO)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .DATA0(DATA0), .GNT0(GNT0),
    .REQ1(REQ1), .DATA1(DATA1), .GNT1(GNT1),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
`ifdef ARB_LOCK_EN
    .LOCK0(LOCK0), .LOCK1(LOCK1),
`endif
    .OUT_DATA(OUT_DATA), .OUT_SRC(OUT_SRC), .SEL(SEL)
  );

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // One row = inputs applied for one cycle and the outputs expected in
  // that cycle, before the next rising edge.
  typedef struct {
    logic        rst, r0, r1, rdy;
    logic [63:0] d0, d1;
    logic        g0, g1, sel, vld;
    logic [63:0] odata;
    logic        osrc;
  } vec_t;

  function automatic vec_t mk(input logic rst, r0, r1, rdy,
                              input logic [63:0] d0, d1,
                              input logic g0, g1, sel, vld,
                              input logic [63:0] odata, input logic osrc);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.rdy = rdy; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.sel = sel; v.vld = vld; v.odata = odata;
    v.osrc = osrc;
    return v;
  endfunction

  vec_t vq[$];

  // Reference model: the output register is a queue of at most one word.
  typedef struct {
    logic [63:0] data;
    logic        src;
  } word_t;

  word_t held[$];
  word_t shown;
  logic  m_last, m_sel;
`ifdef ARB_LOCK_EN
  logic  m_locked, m_owner;
`endif

  function automatic void model_reset();
    held.delete();
    shown  = '{64'd0, 1'b0};
    m_last = ~FIRST_PRIO;
    m_sel  = 1'b0;
`ifdef ARB_LOCK_EN
    m_locked = 1'b0;
    m_owner  = 1'b0;
`endif
  endfunction

  // Check the current cycle against the model, then advance the model over
  // the next rising edge. Inputs must already be driven.
  task automatic tick_model(output logic w0, output logic w1);
    logic room, e0, e1, exp_sel;
    #1;
    room = (held.size() == 0) || OUT_READY;
    e0 = REQ0;
    e1 = REQ1;
`ifdef ARB_LOCK_EN
    if (m_locked) begin
      if (m_owner) e0 = 1'b0;
      else         e1 = 1'b0;
    end
`endif
    w0 = 1'b0;
    w1 = 1'b0;
    if (RST && room) begin
      if (e0 && e1) begin
        w0 = (m_last == 1'b1);
        w1 = (m_last == 1'b0);
      end else begin
        w0 = e0;
        w1 = e1;
      end
    end
    exp_sel = (w0 || w1) ? w1 : m_sel;
    chk("rnd_gnt0", GNT0, w0);
    chk("rnd_gnt1", GNT1, w1);
    chk("rnd_sel", SEL, exp_sel);
    chk("rnd_valid", OUT_VALID, held.size() != 0);
    chk("rnd_data", OUT_DATA, shown.data);
    chk("rnd_src", OUT_SRC, shown.src);
    @(posedge CLK);
    if (!RST) begin
      model_reset();
    end else begin
      if (OUT_READY && held.size() != 0) void'(held.pop_front());
      if (w0 || w1) begin
        shown.data = w1 ? DATA1 : DATA0;
        shown.src  = w1;
        held.push_back(shown);
        m_last = w1;
        m_sel  = w1;
      end
`ifdef ARB_LOCK_EN
      if (w0 || w1) begin
        if (w1 ? LOCK1 : LOCK0) begin
          m_locked = 1'b1;
          m_owner  = w1;
        end else begin
          m_locked = 1'b0;
        end
      end else if (m_locked && !(m_owner ? REQ1 : REQ0)) begin
        m_locked = 1'b0;
      end
`endif
    end
  endtask

  initial begin
    logic w0, w1;
    RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; OUT_READY = 1'b0;
    DATA0 = '0; DATA1 = '0;
`ifdef ARB_LOCK_EN
    LOCK0 = 1'b0; LOCK1 = 1'b0;
`endif
    repeat (2) @(posedge CLK);

    //        rst r0 r1 rdy d0  d1   g0 g1 sel vld odata osrc
    vq.push_back(mk(0, 1, 1, 1, WA, WB, 0, 0, 0, 0, 64'd0, 0)); // in reset
    vq.push_back(mk(1, 1, 0, 1, WA, WB, 1, 0, 0, 0, 64'd0, 0)); // lone req0
    vq.push_back(mk(1, 1, 1, 1, WA, WB, 0, 1, 1, 1, WA, 0));    // alternate
    vq.push_back(mk(1, 1, 1, 1, WA, WB, 1, 0, 0, 1, WB, 1));
    vq.push_back(mk(1, 1, 1, 1, WA, WB, 0, 1, 1, 1, WA, 0));
    vq.push_back(mk(1, 1, 1, 1, WA, WB, 1, 0, 0, 1, WB, 1));
    vq.push_back(mk(1, 1, 1, 0, WA, WB, 0, 0, 0, 1, WA, 0));    // stalled
    vq.push_back(mk(1, 1, 1, 0, WA, WC, 0, 0, 0, 1, WA, 0));
    vq.push_back(mk(1, 1, 1, 0, WA, WC, 0, 0, 0, 1, WA, 0));
    vq.push_back(mk(1, 1, 1, 1, WA, WC, 0, 1, 1, 1, WA, 0));    // drain+refill
    vq.push_back(mk(1, 0, 0, 0, WA, WC, 0, 0, 1, 1, WC, 1));
    vq.push_back(mk(1, 0, 1, 0, WA, WD, 0, 0, 1, 1, WC, 1));    // req1 pulse
    vq.push_back(mk(1, 0, 0, 0, WA, WD, 0, 0, 1, 1, WC, 1));
    vq.push_back(mk(1, 0, 0, 1, WA, WD, 0, 0, 1, 1, WC, 1));    // drain only
    vq.push_back(mk(1, 0, 0, 1, WA, WD, 0, 0, 1, 0, WC, 1));    // stale word
    vq.push_back(mk(1, 1, 0, 0, WD, WB, 1, 0, 0, 0, WC, 1));    // empty, !rdy
    vq.push_back(mk(1, 0, 0, 0, WD, WB, 0, 0, 0, 1, WD, 0));
    vq.push_back(mk(0, 1, 1, 1, WA, WB, 0, 0, 0, 1, WD, 0));    // reset held
    vq.push_back(mk(1, 1, 1, 1, WA, WB, 1, 0, 0, 0, 64'd0, 0)); // first prio
    vq.push_back(mk(1, 0, 0, 1, WA, WB, 0, 0, 0, 1, WA, 0));
    vq.push_back(mk(1, 0, 1, 0, WA, WB, 0, 1, 1, 0, WA, 0));
    vq.push_back(mk(1, 0, 0, 1, WA, WB, 0, 0, 1, 1, WB, 1));

    foreach (vq[i]) begin
      @(negedge CLK);
      RST = vq[i].rst; REQ0 = vq[i].r0; REQ1 = vq[i].r1;
      OUT_READY = vq[i].rdy; DATA0 = vq[i].d0; DATA1 = vq[i].d1;
      #1;
      chk($sformatf("v%0d_gnt0", i), GNT0, vq[i].g0);
      chk($sformatf("v%0d_gnt1", i), GNT1, vq[i].g1);
      chk($sformatf("v%0d_sel", i), SEL, vq[i].sel);
      chk($sformatf("v%0d_valid", i), OUT_VALID, vq[i].vld);
      chk($sformatf("v%0d_data", i), OUT_DATA, vq[i].odata);
      chk($sformatf("v%0d_src", i), OUT_SRC, vq[i].osrc);
    end

    // Randomized traffic against the model, starting from a fresh reset.
    model_reset();
    @(negedge CLK);
    RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
    @(posedge CLK);
    w0 = 1'b0; w1 = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge CLK);
      RST = ($urandom_range(0, 79) != 0);
      // Producers mostly hold request and word until granted, but may drop.
      if (w0 || $urandom_range(0, 7) == 0) begin
        REQ0  = ($urandom_range(0, 2) != 0);
        DATA0 = {$urandom, $urandom};
      end
      if (w1 || $urandom_range(0, 7) == 0) begin
        REQ1  = ($urandom_range(0, 2) != 0);
        DATA1 = {$urandom, $urandom};
      end
      OUT_READY = ($urandom_range(0, 3) != 0);
`ifdef ARB_LOCK_EN
      LOCK0 = ($urandom_range(0, 2) == 0);
      LOCK1 = ($urandom_range(0, 2) == 0);
`endif
      tick_model(w0, w1);
    end

`ifdef ARB_LOCK_EN
    // Requester 0 locks for three words; the third releases the lock.
    @(negedge CLK);
    RST = 1'b0; LOCK0 = 1'b0; LOCK1 = 1'b0;
    @(negedge CLK);
    RST = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; OUT_READY = 1'b1;
    DATA0 = WA; DATA1 = WB;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge CLK);
      LOCK0 = (k < 2);
      #1;
      chk($sformatf("lock%0d_gnt0", k), GNT0, k < 3);
      chk($sformatf("lock%0d_gnt1", k), GNT1, k == 3);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux64_rr_arbiter.md
Name: mux64_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 64-bit 2:1 select datapath.
- Decides each cycle which requester's word passes the mux and captures it into a one-entry output register.
- Presents the captured word downstream with a VALID/READY handshake.
- Sits between two 64-bit producers (e.g. ALU result and memory read-back) and a single consumer bus.

Parameters:
- DATA_W, 64, width of each data word and of the output register.
- FIRST_PRIO, 0, requester that wins the first contested arbitration after reset.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
- REQ0  input  1  requester 0 has a valid word on DATA0.
- DATA0  input  DATA_W  requester 0 word.
- GNT0  output  1  DATA0 is captured at this CLK edge.
- REQ1  input  1  requester 1 has a valid word on DATA1.
- DATA1  input  DATA_W  requester 1 word.
- GNT1  output  1  DATA1 is captured at this CLK edge.
- OUT_VALID  output  1  output register holds a word.
- OUT_READY  input  1  consumer accepts the word this cycle.
- OUT_DATA  output  DATA_W  held word.
- OUT_SRC  output  1  index of the requester that supplied OUT_DATA.
- SEL  output  1  current mux select (0 selects DATA0, 1 selects DATA1); equals the granted index when a grant is active, otherwise holds its last value.

Behaviour:
- Reset (RST=0 at an edge):
  - OUT_VALID=0, OUT_DATA=0, OUT_SRC=0, SEL=0.
  - Round-robin pointer LAST = ~FIRST_PRIO.
  - GNT0=GNT1=0 while RST=0.
  - Any held word is discarded.
- States: EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
- ACCEPT = (state==EMPTY) | (OUT_READY & OUT_VALID). ACCEPT is combinational, so the register can drain and refill in the same cycle.
- Grant logic is Mealy and combinational from state, REQ0/REQ1, LAST and OUT_READY:
  - Only one REQ high and ACCEPT: that requester is granted.
  - Both REQ high and ACCEPT: requester ~LAST is granted.
  - ACCEPT=0: no grant. Requesters must hold REQ and DATA stable until their GNT.
- At a CLK edge with GNTk=1:
  - OUT_DATA <= DATAk, OUT_SRC <= k, LAST <= k, SEL <= k, state <= FULL.
- At an edge with OUT_VALID & OUT_READY and no grant: state <= EMPTY; OUT_DATA and OUT_SRC keep their old values.
- Latency:
  - REQ to GNT: 0 cycles when ACCEPT holds.
  - GNT to OUT_VALID: 1 cycle.
  - Sustained throughput: 1 word/cycle while OUT_READY=1.
- GNT0 and GNT1 are mutually exclusive in every cycle.
- A requester keeping REQ high after its GNT presents its next word. It is not granted twice in a row while the other requester is also requesting.
- A REQ dropped before its grant captures nothing. No state is retained for it.
- FULL with OUT_READY=0: OUT_VALID, OUT_DATA and OUT_SRC remain stable; no grants.
- Words are passed through unmodified at full DATA_W width; no arithmetic is performed.

Optional Feature:
- Macro ARB_LOCK_EN.
- When defined:
  - Adds input ports LOCK0 and LOCK1 (1 bit each).
  - A grant to k with LOCKk=1 sets LOCKED=1, OWNER=k.
  - While LOCKED, only OWNER can be granted; the other requester is held off even if the owner's REQ is low.
  - LOCKED clears at a grant to OWNER with LOCKk=0, or at an edge where OWNER's REQ is 0.
  - Reset clears LOCKED.
- When undefined: ports are absent and behaviour is pure round-robin as above.

Test Plan:
- Reset, then REQ0=1 with DATA0=64'd4294967294 and OUT_READY=1 → GNT0=1 in the same cycle. Next cycle: OUT_VALID=1, OUT_DATA=4294967294, OUT_SRC=0, SEL=0.
- Both REQ held high, DATA0=4294967294, DATA1=4294967295, OUT_READY=1 for 4 cycles → grants alternate 0,1,0,1. OUT_SRC sequence is 0,1,0,1, one word per cycle.
- FULL with OUT_READY=0 for 3 cycles, both REQ high → no GNT and OUT_DATA stable. Raising OUT_READY → drain and refill in one cycle; the grant goes to the requester not last served.
- Word held (OUT_VALID=1) and RST=0 for one cycle → OUT_VALID=0 and OUT_DATA=0 afterwards. After reset, both REQ high → GNT(FIRST_PRIO)=1.
- REQ1 pulsed high for one cycle while FULL and OUT_READY=0 → GNT1 never asserts and OUT_DATA is unchanged.
- With ARB_LOCK_EN: REQ0=LOCK0=1 and REQ1=1 for 3 words → GNT0 three times, GNT1 never. LOCK0=0 on the third grant → the next grant goes to requester 1.
